count_monitor: RTL and testbench

- Receiving end of the 3-bit lap-counter stream. Samples a qualified count value each cycle.
- Checks that the stream runs 0..MAX_VAL in order for NUM_LAPS laps, counts and flags sequence errors, then reports done/pass.
- Sits downstream of the count generator as an in-design checker and self-test status source.

---
 rtl/count_pkg.sv | 20 ++
 rtl/sat_counter.sv | 20 ++
 rtl/count_monitor.sv | 154 +++++++++++++++
 tb/tb_count_monitor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared types and default geometry for the lap-counter stream (generator and monitor).
package count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_CNT_W    = 3;
  localparam int DEF_MAX_VAL  = 7;
  localparam int DEF_NUM_LAPS = 3;

  // Width needed to hold a lap count of 0..n inclusive.
  function automatic int lap_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter with clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Lap-counter stream checker: hunts for a 0, tracks 0..MAX_VAL for NUM_LAPS laps, reports done/pass.
// Optional idle watchdog and timeout output enabled by COUNT_MONITOR_TIMEOUT_EN.
module count_monitor
  import count_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MAX_VAL     = DEF_MAX_VAL,
  parameter int NUM_LAPS    = DEF_NUM_LAPS,
  parameter int ERR_W       = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic [CNT_W-1:0]                    in_count,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic                                err_pulse,
  output logic [ERR_W-1:0]                    err_count,
  output logic [$clog2(NUM_LAPS+1)-1:0]       lap_count,
  output logic [CNT_W-1:0]                    expected
`ifdef COUNT_MONITOR_TIMEOUT_EN
  ,
  output logic                                timeout
`endif
);

  localparam int LAP_W = $clog2(NUM_LAPS + 1);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_VAL);
  localparam logic [LAP_W-1:0] LAPS_C = LAP_W'(NUM_LAPS);

  state_t           state;
  logic             arm;
  logic             track_sample;
  logic             mismatch;
  logic             lap_hit;
  logic             last_lap;
  logic             wd_hit;
  logic [CNT_W-1:0] next_exp;

  assign arm          = start && ((state == IDLE) || (state == DONE));
  assign track_sample = (state == TRACK) && in_valid;
  assign mismatch     = track_sample && (in_count != expected);
  assign lap_hit      = track_sample && (in_count == MAX_C);
  assign last_lap     = lap_hit && ((lap_count + LAP_W'(1)) == LAPS_C);
  // Values at or above the wrap point restart the expected sequence at zero.
  assign next_exp     = (in_count >= MAX_C) ? '0 : in_count + CNT_W'(1);

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (arm),
    .inc   (mismatch),
    .value (err_count)
  );

`ifdef COUNT_MONITOR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_value;
  logic            wd_idle;

  assign wd_idle = ((state == ARMED) || (state == TRACK)) && !in_valid;
  // Fires on the TIMEOUT_CYC-th consecutive idle cycle so DONE lands on that edge.
  assign wd_hit  = wd_idle && (wd_value == WD_W'(TIMEOUT_CYC - 1));

  sat_counter #(.W(WD_W)) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (arm || !wd_idle),
    .inc   (wd_idle),
    .value (wd_value)
  );
`else
  assign wd_hit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_pulse <= 1'b0;
      lap_count <= '0;
      expected  <= '0;
`ifdef COUNT_MONITOR_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
    end else begin
      err_pulse <= mismatch;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= ARMED;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            lap_count <= '0;
            expected  <= '0;
`ifdef COUNT_MONITOR_TIMEOUT_EN
            timeout   <= 1'b0;
`endif
          end
        end
        ARMED: begin
          if (wd_hit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
`ifdef COUNT_MONITOR_TIMEOUT_EN
            timeout <= 1'b1;
`endif
          end else if (in_valid && (in_count == '0)) begin
            state    <= TRACK;
            expected <= CNT_W'(1);
          end
        end
        TRACK: begin
          if (wd_hit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
`ifdef COUNT_MONITOR_TIMEOUT_EN
            timeout <= 1'b1;
`endif
          end else if (in_valid) begin
            expected <= next_exp;
            if (lap_hit) begin
              lap_count <= lap_count + LAP_W'(1);
            end
            if (last_lap) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              // The closing sample may itself be a mismatch that lands in err_count on this edge.
              pass  <= (err_count == '0) && !mismatch;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor; a second instance with ERR_W=2 covers error-count saturation.
// Timeout scenario is built only with COUNT_MONITOR_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_count = 3'd0;

  logic       busy, done, pass, err_pulse;
  logic [7:0] err_count;
  logic [1:0] lap_count;
  logic [2:0] expected;

  logic       s_busy, s_done, s_pass, s_err_pulse;
  logic [1:0] s_err_count;
  logic [1:0] s_lap_count;
  logic [2:0] s_expected;
`ifdef COUNT_MONITOR_TIMEOUT_EN
  logic       timeout, s_timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_monitor dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_count(in_count),
    .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
    .err_count(err_count), .lap_count(lap_count), .expected(expected)
`ifdef COUNT_MONITOR_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  count_monitor #(.ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_count(in_count),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_pulse(s_err_pulse),
    .err_count(s_err_count), .lap_count(s_lap_count), .expected(s_expected)
`ifdef COUNT_MONITOR_TIMEOUT_EN
    , .timeout(s_timeout)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle 1ns past it, release inputs.
  task automatic step(input logic s, input logic v, input logic [2:0] c);
    start = s; in_valid = v; in_count = c;
    @(posedge clk);
    #1;
    $display("t=%0t start=%0b valid=%0b count=%0d -> busy=%0b done=%0b pass=%0b errp=%0b errs=%0d laps=%0d exp=%0d",
             $time, s, v, c, busy, done, pass, err_pulse, err_count, lap_count, expected);
    start = 1'b0; in_valid = 1'b0; in_count = 3'd0;
  endtask

  task automatic clean_lap(input string tag);
    for (int v = 0; v < 8; v++) begin
      step(1'b0, 1'b1, 3'(v));
      check(tag, int'(err_pulse), 0);
    end
  endtask

  task automatic check_done(input string tag, input int exp_pass, input int exp_errs);
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_pass"}, int'(pass), exp_pass);
    check({tag, "_laps"}, int'(lap_count), 3);
    check({tag, "_errs"}, int'(err_count), exp_errs);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step(1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_errp", int'(err_pulse), 0);
    check("rst_errs", int'(err_count), 0);
    check("rst_laps", int'(lap_count), 0);
    check("rst_exp", int'(expected), 0);

    // Clean stream; a sample in the start cycle is not inspected
    step(1'b1, 1'b1, 3'd3);
    check("clean_busy", int'(busy), 1);
    check("clean_exp0", int'(expected), 0);
    clean_lap("clean_l1");
    check("clean_lap1", int'(lap_count), 1);
    check("clean_wrap_exp", int'(expected), 0);
    clean_lap("clean_l2");
    for (int v = 0; v < 7; v++) step(1'b0, 1'b1, 3'(v));
    check("clean_notdone", int'(done), 0);
    step(1'b0, 1'b1, 3'd7);
    check_done("clean", 1, 0);

    // Re-arm from DONE, then late arm: 5,6,7 ignored while hunting
    step(1'b1, 1'b0, 3'd0);
    check("rearm_done", int'(done), 0);
    check("rearm_pass", int'(pass), 0);
    check("rearm_busy", int'(busy), 1);
    check("rearm_laps", int'(lap_count), 0);
    for (int v = 5; v < 8; v++) begin
      step(1'b0, 1'b1, 3'(v));
      check("hunt_errp", int'(err_pulse), 0);
    end
    check("hunt_laps", int'(lap_count), 0);
    check("hunt_exp", int'(expected), 0);
    clean_lap("hunt_l1");
    clean_lap("hunt_l2");
    clean_lap("hunt_l3");
    check_done("hunt", 1, 0);

    // Skipped value in lap 2
    step(1'b1, 1'b0, 3'd0);
    clean_lap("skip_l1");
    step(1'b0, 1'b1, 3'd0);
    step(1'b0, 1'b1, 3'd1);
    step(1'b0, 1'b1, 3'd2);
    step(1'b0, 1'b1, 3'd4);
    check("skip_errp", int'(err_pulse), 1);
    check("skip_exp", int'(expected), 5);
    check("skip_errs", int'(err_count), 1);
    step(1'b0, 1'b1, 3'd5);
    check("skip_errp_drop", int'(err_pulse), 0);
    step(1'b0, 1'b1, 3'd6);
    step(1'b0, 1'b1, 3'd7);
    check("skip_lap2", int'(lap_count), 2);
    clean_lap("skip_l3");
    check_done("skip", 0, 1);

    // Gapped valid: two idle cycles after every sample, expected must hold
    step(1'b1, 1'b0, 3'd0);
    for (int l = 0; l < 3; l++) begin
      for (int v = 0; v < 8; v++) begin
        step(1'b0, 1'b1, 3'(v));
        check("gap_errp", int'(err_pulse), 0);
        if (l < 2 || v < 7) begin
          for (int g = 0; g < 2; g++) begin
            step(1'b0, 1'b0, 3'(v + 3));
            check("gap_hold", int'(expected), (v == 7) ? 0 : v + 1);
          end
        end
      end
    end
    check_done("gap", 1, 0);

    // Reset mid-TRACK; 7 then non-zero is an error; start while busy ignored
    step(1'b1, 1'b0, 3'd0);
    clean_lap("mid_l1");
    step(1'b0, 1'b1, 3'd3);
    check("mid_wrap_err", int'(err_pulse), 1);
    check("mid_exp4", int'(expected), 4);
    step(1'b1, 1'b1, 3'd6);
    check("mid_busy_start_errs", int'(err_count), 2);
    check("mid_busy_start_laps", int'(lap_count), 1);
    check("mid_busy_start_busy", int'(busy), 1);
    check("mid_exp7", int'(expected), 7);
    rst = 1'b1;
    step(1'b0, 1'b1, 3'd7);
    rst = 1'b0;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_errp", int'(err_pulse), 0);
    check("mid_rst_errs", int'(err_count), 0);
    check("mid_rst_laps", int'(lap_count), 0);
    check("mid_rst_exp", int'(expected), 0);
    step(1'b1, 1'b0, 3'd0);
    clean_lap("post_l1");
    clean_lap("post_l2");
    clean_lap("post_l3");
    check_done("post", 1, 0);

    // Saturation (second instance has a 2-bit error counter) and terminal hold
    step(1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 3'd3);
      check("sat_errp", int'(err_pulse), 1);
    end
    check("sat_errs_wide", int'(err_count), 5);
    check("sat_errs_narrow", int'(s_err_count), 3);
    for (int v = 4; v < 8; v++) step(1'b0, 1'b1, 3'(v));
    clean_lap("sat_l2");
    clean_lap("sat_l3");
    check_done("sat", 0, 5);
    check("sat_narrow_done", int'(s_done), 1);
    check("sat_narrow_pass", int'(s_pass), 0);
    check("sat_narrow_errs", int'(s_err_count), 3);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 3'd7);
      check("hold_errp", int'(err_pulse), 0);
      check("hold_laps", int'(lap_count), 3);
      check("hold_done", int'(done), 1);
    end

`ifdef COUNT_MONITOR_TIMEOUT_EN
    step(1'b1, 1'b0, 3'd0);
    check("to_clear", int'(timeout), 0);
    step(1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 3'd0);
    check("to_not_yet", int'(timeout), 0);
    check("to_busy", int'(busy), 1);
    step(1'b0, 1'b0, 3'd0);
    check("to_flag", int'(timeout), 1);
    check("to_done", int'(done), 1);
    check("to_pass", int'(pass), 0);
    step(1'b1, 1'b0, 3'd0);
    check("to_rearm", int'(timeout), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
